// File: rtl/ccu_snoop_arb.sv
// ccu_snoop_arb: shares the single CCU snoop port (AC/CR/CD) between NoReq
// snoop-issuing FSMs. One requester owns the AC grant at a time. CR/CD routing
// stays locked to that requester until its snoop completes.
// Optional feature macro: CCU_SNOOP_ARB_RR_EN.
//   Defined:   round-robin arbitration.
//   Undefined: fixed priority, lowest index wins.

package ccu_snoop_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  // cr_resp bit 0 is DataTransfer and bit 1 is Error.
  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } snoop_resp_t;

endpackage

module ccu_snoop_arb #(
  parameter int unsigned NoReq   = 2,
  parameter int unsigned CdBeats = 4,
  parameter type snoop_req_t     = ccu_snoop_pkg::snoop_req_t,
  parameter type snoop_resp_t    = ccu_snoop_pkg::snoop_resp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  snoop_req_t                 slv_snoop_req_i  [NoReq],
  output snoop_resp_t                slv_snoop_resp_o [NoReq],
  output snoop_req_t                 mst_snoop_req_o,
  input  snoop_resp_t                mst_snoop_resp_i,
  output logic                       busy_o,
  output logic [$clog2(NoReq)-1:0]   gnt_idx_o,
  output logic                       cd_len_err_o
);

  localparam int unsigned IdxW   = $clog2(NoReq);
  localparam int unsigned CntW   = $clog2(CdBeats + 1);
  localparam int unsigned CntMax = (1 << CntW) - 1;

  typedef enum logic [1:0] {
    IDLE,
    AC_HOLD,
    WAIT_CR,
    WAIT_CD
  } state_e;

  state_e            r_state, w_state_d;
  logic [IdxW-1:0]   r_idx, w_idx_d;
  logic [CntW-1:0]   r_beat_cnt, w_beat_cnt_d;
  logic [IdxW-1:0]   w_start;
  logic [IdxW-1:0]   w_winner;
  logic              w_found;
  logic [IdxW-1:0]   w_sel;
  logic              w_ac_valid;
  logic              w_cr_hs;
  logic              w_cd_hs;
  logic              w_len_err;

  // Requester index modulo NoReq, used for the wrapping search and pointer.
  function automatic logic [IdxW-1:0] wrap_idx(input int unsigned v);
    return IdxW'(v % NoReq);
  endfunction

`ifdef CCU_SNOOP_ARB_RR_EN
  logic [IdxW-1:0] r_rr_ptr, w_rr_ptr_d;

  assign w_start = r_rr_ptr;

  // Round-robin pointer: moves past the requester whose AC just handshook.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rr_ptr <= '0;
    else         r_rr_ptr <= w_rr_ptr_d;
  end
`else
  assign w_start = '0;
`endif

  // Winner search: first requester with ac_valid from w_start upward, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < NoReq; k++) begin
      if (!w_found && slv_snoop_req_i[wrap_idx(32'(w_start) + k)].ac_valid) begin
        w_found  = 1'b1;
        w_winner = wrap_idx(32'(w_start) + k);
      end
    end
  end

  assign w_sel   = (r_state == IDLE) ? w_winner : r_idx;
  assign w_cr_hs = (r_state == WAIT_CR) && mst_snoop_resp_i.cr_valid &&
                   slv_snoop_req_i[r_idx].cr_ready;
  assign w_cd_hs = (r_state == WAIT_CD) && mst_snoop_resp_i.cd_valid &&
                   slv_snoop_req_i[r_idx].cd_ready;

  // Combinational routing: payloads pass/broadcast, valids and readies gated.
  always_comb begin
    w_ac_valid      = 1'b0;
    mst_snoop_req_o = '0;
    mst_snoop_req_o.ac = slv_snoop_req_i[w_sel].ac;
    for (int unsigned i = 0; i < NoReq; i++) begin
      slv_snoop_resp_o[i]         = '0;
      slv_snoop_resp_o[i].cr_resp = mst_snoop_resp_i.cr_resp;
      slv_snoop_resp_o[i].cd      = mst_snoop_resp_i.cd;
    end
    case (r_state)
      IDLE: begin
        w_ac_valid = w_found;
        slv_snoop_resp_o[w_sel].ac_ready = w_found & mst_snoop_resp_i.ac_ready;
      end
      AC_HOLD: begin
        w_ac_valid = slv_snoop_req_i[r_idx].ac_valid;
        slv_snoop_resp_o[r_idx].ac_ready = mst_snoop_resp_i.ac_ready;
      end
      WAIT_CR: begin
        mst_snoop_req_o.cr_ready         = slv_snoop_req_i[r_idx].cr_ready;
        slv_snoop_resp_o[r_idx].cr_valid = mst_snoop_resp_i.cr_valid;
      end
      WAIT_CD: begin
        mst_snoop_req_o.cd_ready         = slv_snoop_req_i[r_idx].cd_ready;
        slv_snoop_resp_o[r_idx].cd_valid = mst_snoop_resp_i.cd_valid;
      end
      default: ;
    endcase
    mst_snoop_req_o.ac_valid = w_ac_valid;
  end

  // Next-state logic, grant lock, beat counting and length checking.
  always_comb begin
    w_state_d    = r_state;
    w_idx_d      = r_idx;
    w_beat_cnt_d = r_beat_cnt;
    w_len_err    = 1'b0;
`ifdef CCU_SNOOP_ARB_RR_EN
    w_rr_ptr_d   = r_rr_ptr;
`endif
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_idx_d = w_winner;
          if (mst_snoop_resp_i.ac_ready) begin
            w_state_d = WAIT_CR;
`ifdef CCU_SNOOP_ARB_RR_EN
            w_rr_ptr_d = wrap_idx(32'(w_winner) + 1);
`endif
          end else begin
            w_state_d = AC_HOLD;
          end
        end
      end
      AC_HOLD: begin
        if (slv_snoop_req_i[r_idx].ac_valid && mst_snoop_resp_i.ac_ready) begin
          w_state_d = WAIT_CR;
`ifdef CCU_SNOOP_ARB_RR_EN
          w_rr_ptr_d = wrap_idx(32'(r_idx) + 1);
`endif
        end
      end
      WAIT_CR: begin
        if (w_cr_hs) begin
          if (mst_snoop_resp_i.cr_resp[0]) begin
            w_state_d    = WAIT_CD;
            w_beat_cnt_d = '0;
          end else begin
            w_state_d = IDLE;
          end
        end
      end
      WAIT_CD: begin
        if (w_cd_hs) begin
          if (r_beat_cnt != CntW'(CntMax)) w_beat_cnt_d = r_beat_cnt + 1'b1;
          if (mst_snoop_resp_i.cd.last) begin
            w_state_d = IDLE;
            if ((32'(r_beat_cnt) + 32'd1) != CdBeats) w_len_err = 1'b1;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_d;
  end

  // Locked requester index and CD beat counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx      <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_idx      <= w_idx_d;
      r_beat_cnt <= w_beat_cnt_d;
    end
  end

  assign busy_o       = (r_state != IDLE) | w_ac_valid;
  assign gnt_idx_o    = w_sel;
  assign cd_len_err_o = w_len_err;

endmodule

// File: tb/tb_ccu_snoop_arb.sv
// Directed bench for ccu_snoop_arb (NoReq=2, CdBeats=4). Expected grant order
// follows CCU_SNOOP_ARB_RR_EN when the same define is given to the bench.

module tb_ccu_snoop_arb;

  import ccu_snoop_pkg::*;

  logic        clk;
  logic        rst_n;
  snoop_req_t  req  [2];
  snoop_resp_t resp [2];
  snoop_req_t  mreq;
  snoop_resp_t mresp;
  logic        busy;
  logic [0:0]  gnt;
  logic        lenerr;

  int n_vec = 0;
  int n_err = 0;

  ccu_snoop_arb #(.NoReq(2), .CdBeats(4)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .slv_snoop_req_i  (req),
    .slv_snoop_resp_o (resp),
    .mst_snoop_req_o  (mreq),
    .mst_snoop_resp_i (mresp),
    .busy_o           (busy),
    .gnt_idx_o        (gnt),
    .cd_len_err_o     (lenerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req[0] = '0;
    req[1] = '0;
    mresp  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0]  exp_order [4];
    logic [63:0] beats [4];
    int b;
    int k;

`ifdef CCU_SNOOP_ARB_RR_EN
    exp_order = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    exp_order = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    beats = '{64'hD0, 64'hD1, 64'hD2, 64'hD3};

    // Reset state
    rst_n = 1'b1;
    clear_inputs();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mreq",    mreq, 0);
    chk("rst_ackrdy0", resp[0].ac_ready, 0);
    chk("rst_crv1",    resp[1].cr_valid, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_gnt",     gnt, 0);
    chk("rst_lenerr",  lenerr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // No-data snoop from req0
    req[0].ac_valid  = 1'b1;
    req[0].ac.addr   = 32'h1000;
    req[0].ac.snoop  = 4'h1;
    mresp.ac_ready   = 1'b1;
    #1;
    chk("t1_acv",   mreq.ac_valid, 1);
    chk("t1_addr",  mreq.ac.addr, 32'h1000);
    chk("t1_acr0",  resp[0].ac_ready, 1);
    chk("t1_acr1",  resp[1].ac_ready, 0);
    chk("t1_busy0", busy, 1);
    @(posedge clk); #1;
    req[0].ac_valid  = 1'b0;
    req[0].cr_ready  = 1'b1;
    req[1].cr_ready  = 1'b1;
    mresp.ac_ready   = 1'b0;
    mresp.cr_valid   = 1'b1;
    mresp.cr_resp    = 5'b00000;
    #1;
    chk("t1_crrdy", mreq.cr_ready, 1);
    chk("t1_crv0",  resp[0].cr_valid, 1);
    chk("t1_crv1",  resp[1].cr_valid, 0);
    chk("t1_acv2",  mreq.ac_valid, 0);
    chk("t1_busy1", busy, 1);
    @(posedge clk); #1;
    chk("t1_idle_busy",  busy, 0);
    chk("t1_stray_crr",  mreq.cr_ready, 0);
    chk("t1_stray_crv0", resp[0].cr_valid, 0);
    mresp.cr_valid = 1'b0;

    // Both requesters held across four snoops
    do_reset();
    req[0].ac_valid = 1'b1;  req[0].ac.addr = 32'hA0;  req[0].cr_ready = 1'b1;
    req[1].ac_valid = 1'b1;  req[1].ac.addr = 32'hB0;  req[1].cr_ready = 1'b1;
    mresp.ac_ready  = 1'b1;
    mresp.cr_valid  = 1'b1;
    mresp.cr_resp   = 5'b00000;
    for (int s = 0; s < 4; s++) begin
      #1;
      chk("t2_gnt",  gnt, exp_order[s]);
      chk("t2_addr", mreq.ac.addr, (exp_order[s] == 2'd0) ? 32'hA0 : 32'hB0);
      @(posedge clk); #1;
      chk("t2_hold_acv", mreq.ac_valid, 0);
      chk("t2_busy",     busy, 1);
      chk("t2_crv_own",  (exp_order[s] == 2'd0) ? resp[0].cr_valid : resp[1].cr_valid, 1);
      chk("t2_crv_oth",  (exp_order[s] == 2'd0) ? resp[1].cr_valid : resp[0].cr_valid, 0);
      @(posedge clk); #1;
    end
    clear_inputs();

    // Frozen grant while AC stalls
    do_reset();
    req[1].ac_valid = 1'b1;
    req[1].ac.addr  = 32'h1234;
    req[1].ac.snoop = 4'h7;
    mresp.ac_ready  = 1'b0;
    #1;
    chk("t3_gnt0",  gnt, 1);
    chk("t3_addr0", mreq.ac.addr, 32'h1234);
    @(posedge clk); #1;
    req[0].ac_valid = 1'b1;
    req[0].ac.addr  = 32'h5555;
    #1;
    chk("t3_addr1",  mreq.ac.addr, 32'h1234);
    chk("t3_snoop1", mreq.ac.snoop, 4'h7);
    chk("t3_gnt1",   gnt, 1);
    chk("t3_acr0",   resp[0].ac_ready, 0);
    @(posedge clk); #1;
    chk("t3_addr2",  mreq.ac.addr, 32'h1234);
    chk("t3_acv2",   mreq.ac_valid, 1);
    mresp.ac_ready = 1'b1;
    #1;
    chk("t3_acr1_hs", resp[1].ac_ready, 1);
    chk("t3_acr0_hs", resp[0].ac_ready, 0);
    @(posedge clk); #1;
    req[0].ac_valid = 1'b0;
    req[1].ac_valid = 1'b0;
    mresp.ac_ready  = 1'b0;

    // Data snoop, 4 CD beats with toggling requester ready
    mresp.cr_valid  = 1'b1;
    mresp.cr_resp   = 5'b00001;
    req[1].cr_ready = 1'b1;
    #1;
    chk("t4_crv1", resp[1].cr_valid, 1);
    @(posedge clk); #1;
    mresp.cr_valid = 1'b0;
    b = 0;
    k = 0;
    while (b < 4 && k < 16) begin
      req[1].cd_ready = ((k % 2) == 0);
      mresp.cd_valid  = 1'b1;
      mresp.cd.data   = beats[b];
      mresp.cd.last   = (b == 3);
      #1;
      chk("t4_cdrdy", mreq.cd_ready, req[1].cd_ready);
      chk("t4_cdv1",  resp[1].cd_valid, 1);
      chk("t4_cdv0",  resp[0].cd_valid, 0);
      chk("t4_data",  resp[1].cd.data, beats[b]);
      chk("t4_err",   lenerr, 0);
      if (req[1].cd_ready) b++;
      k++;
      @(posedge clk); #1;
    end
    chk("t4_beats", b, 4);
    mresp.cd_valid = 1'b0;
    #1;
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_cdr",  mreq.cd_ready, 0);
    chk("t4_idle_err",  lenerr, 0);

    // Error response, short CD burst
    do_reset();
    req[0].ac_valid = 1'b1;
    mresp.ac_ready  = 1'b1;
    @(posedge clk); #1;
    req[0].ac_valid = 1'b0;
    mresp.ac_ready  = 1'b0;
    mresp.cr_valid  = 1'b1;
    mresp.cr_resp   = 5'b00011;
    req[0].cr_ready = 1'b1;
    #1;
    chk("t5_crv0", resp[0].cr_valid, 1);
    @(posedge clk); #1;
    mresp.cr_valid  = 1'b0;
    mresp.cd_valid  = 1'b1;
    mresp.cd.data   = 64'h11;
    mresp.cd.last   = 1'b0;
    req[0].cd_ready = 1'b1;
    #1;
    chk("t5_cdv_b1", resp[0].cd_valid, 1);
    chk("t5_err_b1", lenerr, 0);
    @(posedge clk); #1;
    mresp.cd.data = 64'h22;
    mresp.cd.last = 1'b1;
    #1;
    chk("t5_err_b2", lenerr, 1);
    chk("t5_cdv_b2", resp[0].cd_valid, 1);
    @(posedge clk); #1;
    mresp.cd_valid = 1'b0;
    #1;
    chk("t5_err_after", lenerr, 0);
    chk("t5_busy",      busy, 0);

    // Reset asserted in WAIT_CD after one beat
    do_reset();
    req[0].ac_valid = 1'b1;
    mresp.ac_ready  = 1'b1;
    @(posedge clk); #1;
    req[0].ac_valid = 1'b0;
    mresp.ac_ready  = 1'b0;
    mresp.cr_valid  = 1'b1;
    mresp.cr_resp   = 5'b00001;
    req[0].cr_ready = 1'b1;
    @(posedge clk); #1;
    mresp.cr_valid  = 1'b0;
    mresp.cd_valid  = 1'b1;
    mresp.cd.data   = 64'h33;
    mresp.cd.last   = 1'b0;
    req[0].cd_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    mresp.cr_valid = 1'b1;
    #1;
    chk("t6_cdr",  mreq.cd_ready, 0);
    chk("t6_crr",  mreq.cr_ready, 0);
    chk("t6_cdv0", resp[0].cd_valid, 0);
    chk("t6_crv0", resp[0].cr_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_gnt",  gnt, 0);
    @(posedge clk); #1;
    chk("t6_acv",  mreq.ac_valid, 0);
    chk("t6_err",  lenerr, 0);
    rst_n = 1'b1;
    clear_inputs();
    req[1].ac_valid = 1'b1;
    req[1].ac.addr  = 32'h77;
    mresp.ac_ready  = 1'b1;
    #1;
    chk("t6_new_gnt",  gnt, 1);
    chk("t6_new_acr1", resp[1].ac_ready, 1);
    chk("t6_new_addr", mreq.ac.addr, 32'h77);
    @(posedge clk); #1;
    req[1].ac_valid = 1'b0;
    req[1].cr_ready = 1'b1;
    mresp.ac_ready  = 1'b0;
    #1;
    chk("t6_new_crr",  mreq.cr_ready, 1);
    chk("t6_new_busy", busy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
